// File: rtl/video_pkg.sv
// Shared video types: RGB888 pixel, bounding box and colour-window records.
package video_pkg;

  localparam int H_ACT_DEFAULT = 640;
  localparam int V_ACT_DEFAULT = 480;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef struct packed {
    logic [11:0] x0;
    logic [11:0] x1;
    logic [11:0] y0;
    logic [11:0] y1;
  } bbox_t;

  typedef struct packed {
    logic [7:0] r_min;
    logic [7:0] r_max;
    logic [7:0] g_min;
    logic [7:0] g_max;
    logic [7:0] b_min;
    logic [7:0] b_max;
  } rgb_window_t;

  // A window that can never match (min above max on every channel).
  localparam rgb_window_t WIN_CLOSED = '{
    r_min: 8'hFF, r_max: 8'h00,
    g_min: 8'hFF, g_max: 8'h00,
    b_min: 8'hFF, b_max: 8'h00
  };

  // True when every channel of px lies inside the inclusive bounds of w.
  function automatic logic in_window(input rgb888_t px, input rgb_window_t w);
    logic r_ok;
    logic g_ok;
    logic b_ok;
    r_ok = (px.r >= w.r_min) && (px.r <= w.r_max);
    g_ok = (px.g >= w.g_min) && (px.g <= w.g_max);
    b_ok = (px.b >= w.b_min) && (px.b <= w.b_max);
    return r_ok && g_ok && b_ok;
  endfunction

endpackage

// File: rtl/blob_bbox_acc.sv
// Colour-window match, per-frame bounding-box/count accumulation and
// frame-end latch of the box that drives the overlay on the next frame.
module blob_bbox_acc
  import video_pkg::*;
#(
  parameter int H_ACT      = H_ACT_DEFAULT,
  parameter int V_ACT      = V_ACT_DEFAULT,
  parameter int MIN_PIXELS = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        de_i,
  input  rgb888_t     data_i,
  input  logic [11:0] x_i,
  input  logic [11:0] y_i,
  input  rgb_window_t thr_i,
  output bbox_t       box_o,
  output logic        box_valid_o,
  output logic [19:0] pix_count_o
);

  rgb_window_t win_q;
  logic [11:0] min_x_q, max_x_q, min_y_q, max_y_q;
  logic [11:0] min_x_d, max_x_d, min_y_d, max_y_d;
  logic [19:0] cnt_q, cnt_d;
  logic        match_s;
  logic        frame_end_s;
  logic        valid_d;
  bbox_t       box_q;
  logic        box_valid_q;
  logic [19:0] pix_count_q;

  // Match test and accumulator next-state including the current pixel.
  always_comb begin
    match_s     = de_i && in_window(data_i, win_q);
    frame_end_s = de_i && (x_i == 12'(H_ACT - 1)) && (y_i == 12'(V_ACT - 1));
    min_x_d     = (match_s && (x_i < min_x_q)) ? x_i : min_x_q;
    max_x_d     = (match_s && (x_i > max_x_q)) ? x_i : max_x_q;
    min_y_d     = (match_s && (y_i < min_y_q)) ? y_i : min_y_q;
    max_y_d     = (match_s && (y_i > max_y_q)) ? y_i : max_y_q;
    cnt_d       = (match_s && (cnt_q != 20'hFFFFF)) ? (cnt_q + 20'd1) : cnt_q;
    valid_d     = (cnt_d >= 20'(MIN_PIXELS));
  end

  // Accumulate during the frame; on the last pixel latch results, clear
  // the accumulators and load the window to be used for the next frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      win_q       <= WIN_CLOSED;
      min_x_q     <= 12'hFFF;
      max_x_q     <= 12'h000;
      min_y_q     <= 12'hFFF;
      max_y_q     <= 12'h000;
      cnt_q       <= 20'd0;
      box_q       <= '0;
      box_valid_q <= 1'b0;
      pix_count_q <= 20'd0;
    end else if (frame_end_s) begin
      win_q       <= thr_i;
      min_x_q     <= 12'hFFF;
      max_x_q     <= 12'h000;
      min_y_q     <= 12'hFFF;
      max_y_q     <= 12'h000;
      cnt_q       <= 20'd0;
      pix_count_q <= cnt_d;
      box_valid_q <= valid_d;
      if (valid_d) begin
        box_q <= '{x0: min_x_d, x1: max_x_d, y0: min_y_d, y1: max_y_d};
      end else begin
        box_q <= box_q;
      end
    end else begin
      min_x_q <= min_x_d;
      max_x_q <= max_x_d;
      min_y_q <= min_y_d;
      max_y_q <= max_y_d;
      cnt_q   <= cnt_d;
    end
  end

  assign box_o       = box_q;
  assign box_valid_o = box_valid_q;
  assign pix_count_o = pix_count_q;

endmodule

// File: rtl/blob_box_overlay.sv
// Finds pixels inside a programmable RGB window, tracks their bounding box
// per frame and draws the previous frame's box as an outline on the stream.
module blob_box_overlay
  import video_pkg::*;
#(
  parameter int          H_ACT      = H_ACT_DEFAULT,
  parameter int          V_ACT      = V_ACT_DEFAULT,
  parameter logic [23:0] BOX_COLOR  = 24'hFF0000,
  parameter int          LINE_W     = 2,
  parameter int          MIN_PIXELS = 16
) (
  input  logic        video_clk,
  input  logic        rst,
  input  logic        i_hs,
  input  logic        i_vs,
  input  logic        i_de,
  input  logic [23:0] i_data,
  input  logic [11:0] i_x,
  input  logic [11:0] i_y,
  input  logic [7:0]  thr_r_min,
  input  logic [7:0]  thr_r_max,
  input  logic [7:0]  thr_g_min,
  input  logic [7:0]  thr_g_max,
  input  logic [7:0]  thr_b_min,
  input  logic [7:0]  thr_b_max,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_de,
  output logic [23:0] o_data,
  output logic        box_valid,
  output logic [11:0] box_x0,
  output logic [11:0] box_x1,
  output logic [11:0] box_y0,
  output logic [11:0] box_y1,
  output logic [19:0] pix_count
);

  rgb_window_t thr_s;
  rgb888_t     pix_s;
  bbox_t       box_s;
  logic        box_valid_s;

  logic [12:0] x_s, y_s, bx0_s, bx1_s, by0_s, by1_s, lw_s;
  logic        in_xs_s, in_ys_s, near_x_s, near_y_s, border_s;

  logic        hs1_q, vs1_q, de1_q, border1_q;
  logic [23:0] data1_q;
  logic        hs2_q, vs2_q, de2_q;
  logic [23:0] data2_q;

  assign thr_s = {thr_r_min, thr_r_max, thr_g_min, thr_g_max, thr_b_min, thr_b_max};
  assign pix_s = i_data;

  blob_bbox_acc #(
    .H_ACT      (H_ACT),
    .V_ACT      (V_ACT),
    .MIN_PIXELS (MIN_PIXELS)
  ) u_acc (
    .clk_i       (video_clk),
    .rst_i       (rst),
    .de_i        (i_de),
    .data_i      (pix_s),
    .x_i         (i_x),
    .y_i         (i_y),
    .thr_i       (thr_s),
    .box_o       (box_s),
    .box_valid_o (box_valid_s),
    .pix_count_o (pix_count)
  );

  // Outline decode in 13 bits; the right/bottom edge test is written as
  // c + LINE_W - 1 >= edge so a box edge smaller than LINE_W cannot wrap.
  always_comb begin
    x_s      = {1'b0, i_x};
    y_s      = {1'b0, i_y};
    bx0_s    = {1'b0, box_s.x0};
    bx1_s    = {1'b0, box_s.x1};
    by0_s    = {1'b0, box_s.y0};
    by1_s    = {1'b0, box_s.y1};
    lw_s     = 13'(LINE_W);
    in_xs_s  = (x_s >= bx0_s) && (x_s <= bx1_s);
    in_ys_s  = (y_s >= by0_s) && (y_s <= by1_s);
    near_x_s = in_xs_s && ((x_s <= bx0_s + lw_s - 13'd1) || (x_s + lw_s - 13'd1 >= bx1_s));
    near_y_s = in_ys_s && ((y_s <= by0_s + lw_s - 13'd1) || (y_s + lw_s - 13'd1 >= by1_s));
    border_s = box_valid_s && ((in_ys_s && near_x_s) || (in_xs_s && near_y_s));
  end

  // Stage 1: register syncs, pixel and the outline decision.
  always_ff @(posedge video_clk) begin
    if (rst) begin
      hs1_q     <= 1'b0;
      vs1_q     <= 1'b0;
      de1_q     <= 1'b0;
      data1_q   <= 24'h000000;
      border1_q <= 1'b0;
    end else begin
      hs1_q     <= i_hs;
      vs1_q     <= i_vs;
      de1_q     <= i_de;
      data1_q   <= i_data;
      border1_q <= border_s;
    end
  end

  // Stage 2: substitute the box colour on outline pixels, blank outside de.
  always_ff @(posedge video_clk) begin
    if (rst) begin
      hs2_q   <= 1'b0;
      vs2_q   <= 1'b0;
      de2_q   <= 1'b0;
      data2_q <= 24'h000000;
    end else begin
      hs2_q   <= hs1_q;
      vs2_q   <= vs1_q;
      de2_q   <= de1_q;
      if (!de1_q) begin
        data2_q <= 24'h000000;
      end else if (border1_q) begin
        data2_q <= BOX_COLOR;
      end else begin
        data2_q <= data1_q;
      end
    end
  end

  assign o_hs      = hs2_q;
  assign o_vs      = vs2_q;
  assign o_de      = de2_q;
  assign o_data    = data2_q;
  assign box_valid = box_valid_s;
  assign box_x0    = box_s.x0;
  assign box_x1    = box_s.x1;
  assign box_y0    = box_s.y0;
  assign box_y1    = box_s.y1;

endmodule
